pcie_tx_tlp_framer: RTL and testbench

PCIE_TX_TLP_FRAMER -- requirements
Module: pcie_tx_tlp_framer

---
 rtl/pcie_pkg.sv | 18 +
 rtl/pcie_tx_tlp_framer_if.sv | 13 +
 rtl/sync_fifo.sv | 27 ++
 rtl/pcie_tx_tlp_framer.sv | 97 +++++++++
 tb/tb_pcie_tx_tlp_framer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pcie_pkg.sv
// pcie_pkg: shared TLP constants, 4DW header layout and framer state encoding
package pcie_pkg;
   localparam logic [2:0] FMT_MWR_4DW = 3'b011;
   localparam logic [4:0] TYPE_MEM = 5'b00000;
   typedef struct packed {
      logic [31:0] dw3;
      logic [31:0] dw2;
      logic [31:0] dw1;
      logic [2:0]  fmt;
      logic [4:0]  typ;
      logic [13:0] attr_tc;
      logic [9:0]  length;
   } tlp_hdr_4dw_t;
   typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} fsm_state_t;
   function automatic logic [16:0] min3(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c);
      return a < b ? (a < c ? a : c) : (b < c ? b : c);
   endfunction
endpackage

// File: rtl/pcie_tx_tlp_framer_if.sv
// pcie_tx_tlp_framer_if: payload beat input and TLP beat output handshakes
interface pcie_tx_tlp_framer_if #(parameter int PCIE_DATA_WIDTH = 128);
   logic [PCIE_DATA_WIDTH-1:0] s_data;
   logic                       s_valid;
   logic                       s_ready;
   logic [PCIE_DATA_WIDTH-1:0] m_tlp_data;
   logic                       m_tlp_valid;
   logic                       m_tlp_ready;
   logic                       m_tlp_sop;
   logic                       m_tlp_eop;
   modport master (input s_data, s_valid, m_tlp_ready, output s_ready, m_tlp_data, m_tlp_valid, m_tlp_sop, m_tlp_eop);
   modport slave (output s_data, s_valid, m_tlp_ready, input s_ready, m_tlp_data, m_tlp_valid, m_tlp_sop, m_tlp_eop);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular buffer holding one TLP's payload beats
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 128
) (
   input  logic             pcie_clk,
   input  logic             pcie_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   always_ff @(posedge pcie_clk or negedge pcie_rst_n)
      if (!pcie_rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr == AW'(DEPTH - 1) ? '0 : r_wr + AW'(1);
         if (i_pop) r_rd <= r_rd == AW'(DEPTH - 1) ? '0 : r_rd + AW'(1);
      end
   always_ff @(posedge pcie_clk)
      if (i_push) r_mem[r_wr] <= i_din;
   assign o_dout = r_mem[r_rd];
endmodule

// File: rtl/pcie_tx_tlp_framer.sv
// pcie_tx_tlp_framer: packs payload beats into 4DW MWr TLPs written round a host ring buffer
module pcie_tx_tlp_framer
   import pcie_pkg::*;
#(
   parameter int PCIE_DATA_WIDTH   = 128,
   parameter int MAX_PAYLOAD_BEATS = 8,
   parameter int TIMEOUT_CYCLES    = 256
) (
   input  logic                 pcie_clk,
   input  logic                 pcie_rst_n,
   pcie_tx_tlp_framer_if.master bus,
   input  logic                 cfg_enable,
   input  logic [63:0]          cfg_base_addr,
   input  logic [15:0]          cfg_buf_beats,
   input  logic [15:0]          cfg_requester_id,
   output logic [31:0]          tlp_count
);
   localparam int HW = $clog2(MAX_PAYLOAD_BEATS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   fsm_state_t                 r_state, w_next;
   tlp_hdr_4dw_t               r_hdr, w_hdr;
   logic [HW-1:0]              r_held;
   logic [TW-1:0]              r_to;
   logic [15:0]                r_offset, r_buf;
   logic [7:0]                 r_tag;
   logic [31:0]                r_tlp_count;
   logic [63:0]                w_addr;
   logic [16:0]                w_target, w_sum;
   logic [PCIE_DATA_WIDTH-1:0] w_fifo_dout;
   logic                       w_push, w_pop, w_last, w_exit;
   // TLP size is bounded by max payload, ring wrap and the next 4 KB page
   assign w_addr   = (cfg_base_addr & ~64'hF) + {44'h0, r_offset, 4'h0};
   assign w_target = min3(17'(MAX_PAYLOAD_BEATS), {1'b0, cfg_buf_beats} - {1'b0, r_offset}, 17'd256 - {9'h0, w_addr[11:4]});
   assign w_exit   = r_held != '0 && (17'(r_held) >= w_target || r_to == TW'(TIMEOUT_CYCLES) || !cfg_enable);
   assign w_push   = bus.s_valid && bus.s_ready;
   assign w_pop    = r_state == PAYLOAD && bus.m_tlp_ready;
   assign w_last   = r_held == HW'(1);
   assign w_sum    = {1'b0, r_offset} + 17'(r_hdr.length[9:2]);
   assign tlp_count = r_tlp_count;
   always_comb begin
      w_hdr        = '0;
      w_hdr.fmt    = FMT_MWR_4DW;
      w_hdr.typ    = TYPE_MEM;
      w_hdr.length = 10'({r_held, 2'b00});
      w_hdr.dw1    = {cfg_requester_id, r_tag, 8'hFF};
      w_hdr.dw2    = w_addr[63:32];
      w_hdr.dw3    = w_addr[31:0];
   end
   always_comb begin
      w_next = r_state == COLLECT ? (w_exit ? HEADER : COLLECT) :
               r_state == HEADER  ? (bus.m_tlp_ready ? PAYLOAD : HEADER) :
               (bus.m_tlp_ready && w_last ? COLLECT : PAYLOAD);
      bus.s_ready     = pcie_rst_n && r_state == COLLECT && cfg_enable && !w_exit && 17'(r_held) < w_target;
      bus.m_tlp_valid = r_state != COLLECT;
      bus.m_tlp_sop   = r_state == HEADER;
      bus.m_tlp_eop   = r_state == PAYLOAD && w_last;
      bus.m_tlp_data  = r_state == HEADER ? PCIE_DATA_WIDTH'(r_hdr) : r_state == PAYLOAD ? w_fifo_dout : '0;
   end
   always_ff @(posedge pcie_clk or negedge pcie_rst_n)
      if (!pcie_rst_n) r_state <= COLLECT;
      else r_state <= w_next;
   // r_held counts beats collected, then counts down the beats still to drain
   always_ff @(posedge pcie_clk or negedge pcie_rst_n)
      if (!pcie_rst_n) begin
         r_held      <= '0;
         r_to        <= '0;
         r_offset    <= '0;
         r_buf       <= '0;
         r_tag       <= '0;
         r_tlp_count <= '0;
         r_hdr       <= '0;
      end else begin
         r_to   <= (r_state != COLLECT || w_push || r_held == '0) ? '0 : r_to + TW'(1);
         r_held <= w_push ? r_held + HW'(1) : w_pop ? r_held - HW'(1) : r_held;
         if (r_state == COLLECT && w_exit) begin
            r_hdr <= w_hdr;
            r_buf <= cfg_buf_beats;
         end
         if (r_state == COLLECT && r_held == '0 && !cfg_enable) begin
            r_offset <= '0;
            r_tag    <= '0;
         end
         if (w_pop && w_last) begin
            r_offset    <= w_sum >= {1'b0, r_buf} ? 16'(w_sum - {1'b0, r_buf}) : w_sum[15:0];
            r_tag       <= r_tag + 8'd1;
            r_tlp_count <= r_tlp_count + 32'd1;
         end
      end
   sync_fifo #(.DEPTH(MAX_PAYLOAD_BEATS), .WIDTH(PCIE_DATA_WIDTH)) u_fifo (
      .pcie_clk  (pcie_clk),
      .pcie_rst_n(pcie_rst_n),
      .i_push    (w_push),
      .i_din     (bus.s_data),
      .i_pop     (w_pop),
      .o_dout    (w_fifo_dout)
   );
endmodule

// File: tb/tb_pcie_tx_tlp_framer.sv
// tb_pcie_tx_tlp_framer: random beat streams scored against a TLP-level reference model
module tb_pcie_tx_tlp_framer;
   typedef struct {
      logic [127:0] d;
      logic         sop;
      logic         eop;
   } exp_t;
   logic        pcie_clk = 0;
   logic        pcie_rst_n = 0;
   logic        cfg_enable = 0;
   logic [63:0] cfg_base_addr = 0;
   logic [15:0] cfg_buf_beats = 16'd64;
   logic [15:0] cfg_requester_id = 0;
   logic [31:0] tlp_count;
   exp_t        q[$];
   int          errors = 0, checks = 0, exp_count = 0;
   bit          rnd_ready = 0;
   pcie_tx_tlp_framer_if #(.PCIE_DATA_WIDTH(128)) bus();
   pcie_tx_tlp_framer dut (
      .pcie_clk        (pcie_clk),
      .pcie_rst_n      (pcie_rst_n),
      .bus             (bus),
      .cfg_enable      (cfg_enable),
      .cfg_base_addr   (cfg_base_addr),
      .cfg_buf_beats   (cfg_buf_beats),
      .cfg_requester_id(cfg_requester_id),
      .tlp_count       (tlp_count)
   );
   always #5 pcie_clk = ~pcie_clk;
   task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Split a beat stream into TLPs by the sizing rules, starting from offset 0 / tag 0
   task automatic model(input logic [63:0] base, input int ring, input logic [15:0] rid, input logic [127:0] beats[$]);
      int off, tag, i, tgt, n, page;
      logic [63:0] addr;
      exp_t e;
      off = 0; tag = 0; i = 0;
      while (i < beats.size()) begin
         addr = (base & ~64'hF) + 64'(off * 16);
         page = (4096 - int'(addr % 64'd4096)) / 16;
         tgt = 8;
         if (ring - off < tgt) tgt = ring - off;
         if (page < tgt) tgt = page;
         n = beats.size() - i < tgt ? beats.size() - i : tgt;
         e.d = {addr[31:0], addr[63:32], rid, 8'(tag), 8'hFF, 3'b011, 5'b00000, 14'h0, 10'(n * 4)};
         e.sop = 1; e.eop = 0;
         q.push_back(e);
         for (int k = 0; k < n; k++) begin
            e.d = beats[i + k]; e.sop = 0; e.eop = (k == n - 1);
            q.push_back(e);
         end
         i += n;
         off = (off + n) % ring;
         tag = (tag + 1) % 256;
         exp_count++;
      end
   endtask
   task automatic send(input logic [127:0] d);
      int n = 0;
      bus.s_data = d;
      bus.s_valid = 1;
      @(negedge pcie_clk);
      while (!bus.s_ready && n < 3000) begin
         @(negedge pcie_clk);
         n++;
      end
      if (!bus.s_ready) begin
         errors++; checks++;
         $display("FAIL send_stall: s_ready=0 expected 1");
      end
      @(posedge pcie_clk);
      #1 bus.s_valid = 0;
   endtask
   task automatic drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge pcie_clk);
         n++;
      end
      repeat (3) @(posedge pcie_clk);
      #1;
      chk("drain_left", q.size(), 0);
      chk("tlp_count", tlp_count, exp_count);
   endtask
   task automatic run(input logic [63:0] base, input int ring, input int nb, input int gmax, input bit rr, input bit by_timeout);
      logic [127:0] beats[$];
      logic [15:0] rid;
      rid = 16'($urandom);
      for (int i = 0; i < nb; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
      cfg_base_addr = base; cfg_buf_beats = 16'(ring); cfg_requester_id = rid;
      rnd_ready = rr; cfg_enable = 1;
      model(base, ring, rid, beats);
      foreach (beats[i]) begin
         send(beats[i]);
         repeat ($urandom_range(0, gmax)) begin @(posedge pcie_clk); #1; end
      end
      if (by_timeout) begin
         repeat (200) @(posedge pcie_clk);
         #1 chk("no_early_flush", bus.m_tlp_valid, 0);
         drain(600);
      end else begin
         cfg_enable = 0;
         drain(3000);
      end
      cfg_enable = 0;
      repeat (2) @(posedge pcie_clk);
      #1 cfg_enable = 1;
   endtask
   initial begin
      bus.m_tlp_ready = 1;
      forever begin
         @(posedge pcie_clk);
         #1 bus.m_tlp_ready = rnd_ready ? 1'($urandom) : 1'b1;
      end
   end
   initial begin
      exp_t e;
      logic p_valid, p_sop, p_eop, p_ready;
      logic [127:0] p_data;
      p_valid = 0; p_sop = 0; p_eop = 0; p_ready = 0; p_data = 0;
      forever begin
         @(negedge pcie_clk);
         if (!pcie_rst_n) p_valid = 0;
         else begin
            if (p_valid && !p_ready)
               chk("hold", {bus.m_tlp_valid, bus.m_tlp_sop, bus.m_tlp_eop, bus.m_tlp_data}, {1'b1, p_sop, p_eop, p_data});
            if (bus.m_tlp_valid && bus.m_tlp_ready) begin
               if (q.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL unexpected_beat: got %0h expected no beat", bus.m_tlp_data);
               end else begin
                  e = q.pop_front();
                  chk("beat", {1'b0, bus.m_tlp_sop, bus.m_tlp_eop, bus.m_tlp_data}, {1'b0, e.sop, e.eop, e.d});
               end
            end
            p_valid = bus.m_tlp_valid; p_ready = bus.m_tlp_ready;
            p_sop = bus.m_tlp_sop; p_eop = bus.m_tlp_eop; p_data = bus.m_tlp_data;
         end
      end
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end
   initial begin
      logic [63:0] b;
      logic [127:0] beats[$];
      int n;
      bus.s_valid = 0; bus.s_data = 0; cfg_enable = 1;
      repeat (3) @(posedge pcie_clk);
      #1;
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_valid", bus.m_tlp_valid, 0);
      chk("rst_sop", bus.m_tlp_sop, 0);
      chk("rst_eop", bus.m_tlp_eop, 0);
      chk("rst_data", bus.m_tlp_data, 0);
      chk("rst_count", tlp_count, 0);
      @(negedge pcie_clk) pcie_rst_n = 1;
      @(posedge pcie_clk);
      #1;
      run(64'h1_0000_0000, 64, 16, 0, 0, 0);
      run(64'h1_0000_0000, 64, 3, 0, 0, 1);
      run(64'h2_0000_0000, 10, 24, 0, 1, 0);
      run(64'h1_0000_0FC0, 64, 12, 0, 0, 0);
      for (int t = 0; t < 20; t++) begin
         b = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) b[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
         run(b, $urandom_range(1, 20), $urandom_range(1, 30), 3, 1, 0);
      end
      // One TLP completes, the next is cut by reset in the middle of its payload
      cfg_base_addr = 64'h3_0000_0000; cfg_buf_beats = 16'd64; cfg_requester_id = 16'hBEEF;
      rnd_ready = 0; cfg_enable = 1;
      for (int i = 0; i < 16; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
      model(64'h3_0000_0000, 64, 16'hBEEF, beats);
      foreach (beats[i]) send(beats[i]);
      n = 0;
      while (!(bus.m_tlp_valid && !bus.m_tlp_sop && !bus.m_tlp_eop && tlp_count == 32'(exp_count - 1)) && n < 200) begin
         @(negedge pcie_clk);
         n++;
      end
      chk("reach_payload", bus.m_tlp_valid && !bus.m_tlp_sop, 1);
      @(posedge pcie_clk);
      #2 pcie_rst_n = 0;
      q.delete();
      exp_count = 0;
      #1;
      chk("mid_rst_valid", bus.m_tlp_valid, 0);
      chk("mid_rst_sop", bus.m_tlp_sop, 0);
      chk("mid_rst_eop", bus.m_tlp_eop, 0);
      chk("mid_rst_data", bus.m_tlp_data, 0);
      chk("mid_rst_count", tlp_count, 0);
      chk("mid_rst_s_ready", bus.s_ready, 0);
      @(negedge pcie_clk) pcie_rst_n = 1;
      @(posedge pcie_clk);
      #1;
      run(64'h3_0000_0000, 64, 10, 1, 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
